// File: rtl/tmnt_pkg.sv
// Shared types and defaults for the synth front-panel controllers.
package tmnt_pkg;

  // Waveform selection presented to the oscillator path.
  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_SQUARE   = 2'b01,
    MODE_TRIANGLE = 2'b10,
    MODE_SAW      = 2'b11
  } mode_t;

  // Push-button debounce states.
  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    DEB_PRESS   = 2'b01,
    HELD        = 2'b10,
    DEB_RELEASE = 2'b11
  } key_state_t;

  localparam int DEB_CYCLES_DEF  = 1000;
  localparam int MUTE_CYCLES_DEF = 256;

  // Next waveform in the rotation; sawtooth wraps back to off.
  function automatic mode_t mode_next(input mode_t cur);
    return mode_t'(cur + 2'b01);
  endfunction

endpackage

// File: rtl/mode_ctrl_key_debounce.sv
// Synchronises and debounces one push-button; emits a single-cycle pulse
// per clean press. Holding the button never repeats.
module key_debounce
  import tmnt_pkg::*;
#(
  parameter  int DEB_CYCLES = DEB_CYCLES_DEF,
  localparam int DEB_W      = $clog2(DEB_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press_pulse
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] CNT_ZERO = {DEB_W{1'b0}};
  localparam logic [DEB_W-1:0] CNT_ONE  = DEB_W'(1);

  logic             sync_meta_r;
  logic             key_s_r;
  key_state_t       state_r;
  key_state_t       state_s;
  logic [DEB_W-1:0] cnt_r;
  logic [DEB_W-1:0] cnt_s;
  logic             press_s;
  logic             press_pulse_r;

  // Two-flop synchroniser: the raw pad never reaches any other logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_r <= 1'b0;
      key_s_r     <= 1'b0;
    end else begin
      sync_meta_r <= key_raw;
      key_s_r     <= sync_meta_r;
    end
  end

  // State and debounce counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and counter logic; any level change restarts the qualification.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (key_s_r) begin
          state_s = DEB_PRESS;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end
      end
      DEB_PRESS: begin
        if (!key_s_r) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s = HELD;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = DEB_PRESS;
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      HELD: begin
        if (!key_s_r) begin
          state_s = DEB_RELEASE;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = HELD;
          cnt_s   = CNT_ZERO;
        end
      end
      DEB_RELEASE: begin
        if (key_s_r) begin
          state_s = HELD;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = DEB_RELEASE;
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Accept decode: the press qualifies on the final stable debounce cycle.
  always_comb begin
    if ((state_r == DEB_PRESS) && key_s_r && (cnt_r == CNT_LAST)) begin
      press_s = 1'b1;
    end else begin
      press_s = 1'b0;
    end
  end

  // Register the accept so the pulse leaves the block glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_pulse_r <= 1'b0;
    end else begin
      press_pulse_r <= press_s;
    end
  end

  assign press_pulse = press_pulse_r;

endmodule

// File: rtl/mode_ctrl.sv
// Waveform-mode front end: debounced button advances the 2-bit mode,
// with a change strobe and a mute window to hide the switching click.
module mode_ctrl
  import tmnt_pkg::*;
#(
  parameter  int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter  int MUTE_CYCLES = MUTE_CYCLES_DEF,
  localparam int MUTE_W      = $clog2(MUTE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       modekey_raw,
  output logic [1:0] mode,
  output logic       mode_strobe,
  output logic       mute
);

  localparam logic [MUTE_W-1:0] MUTE_LOAD = MUTE_W'(MUTE_CYCLES);
  localparam logic [MUTE_W-1:0] MUTE_ZERO = {MUTE_W{1'b0}};
  localparam logic [MUTE_W-1:0] MUTE_ONE  = MUTE_W'(1);

  logic              press_pulse_s;
  mode_t             mode_r;
  logic              mode_strobe_r;
  logic [MUTE_W-1:0] mute_cnt_r;
  logic [MUTE_W-1:0] mute_cnt_s;
  logic              mute_r;

  key_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_key_debounce (
    .clk         (clk),
    .rst         (rst),
    .key_raw     (modekey_raw),
    .press_pulse (press_pulse_s)
  );

  // Mute countdown: an accept reloads (never stacks), otherwise count down to zero.
  always_comb begin
    mute_cnt_s = mute_cnt_r;
    if (press_pulse_s) begin
      mute_cnt_s = MUTE_LOAD;
    end else if (mute_cnt_r != MUTE_ZERO) begin
      mute_cnt_s = mute_cnt_r - MUTE_ONE;
    end else begin
      mute_cnt_s = MUTE_ZERO;
    end
  end

  // Mode register, change strobe and mute window, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r        <= MODE_OFF;
      mode_strobe_r <= 1'b0;
      mute_cnt_r    <= MUTE_ZERO;
      mute_r        <= 1'b0;
    end else begin
      if (press_pulse_s) begin
        mode_r <= mode_next(mode_r);
      end else begin
        mode_r <= mode_r;
      end
      mode_strobe_r <= press_pulse_s;
      mute_cnt_r    <= mute_cnt_s;
      mute_r        <= (mute_cnt_s != MUTE_ZERO);
    end
  end

  assign mode        = mode_r;
  assign mode_strobe = mode_strobe_r;
  assign mute        = mute_r;

endmodule

// File: tb/tb_mode_ctrl.sv
// Scoreboard bench for mode_ctrl: stimulus pushes expected strobes,
// monitors pop them and track the expected mode/mute each cycle.
module tb_mode_ctrl;

  localparam int DEB   = 8;
  localparam int MUTE  = 16;
  localparam int DEB2  = 2;
  localparam int LAT   = DEB + 4;   // raise at negedge c -> strobe seen at negedge c+LAT
  localparam int LAT2  = DEB2 + 4;

  typedef struct {
    logic [1:0] mode;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw1, raw2;
  logic [1:0] mode1, mode2;
  logic       strobe1, strobe2, mute1, mute2;

  exp_t       q1[$];
  exp_t       q2[$];
  int         n_vec  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  logic       rst_seen = 1'b0;
  logic       mon_en   = 1'b0;
  logic [1:0] nm1 = 2'b00;
  logic [1:0] nm2 = 2'b00;
  int         n_strobe2 = 0;
  int         n_mute2_hi = 0;

  always #5 clk = ~clk;

  mode_ctrl #(.DEB_CYCLES(DEB), .MUTE_CYCLES(MUTE)) u_dut (
    .clk(clk), .rst(rst), .modekey_raw(raw1),
    .mode(mode1), .mode_strobe(strobe1), .mute(mute1)
  );

  // Second instance with a short debounce so two accepts can land 10 cycles apart.
  mode_ctrl #(.DEB_CYCLES(DEB2), .MUTE_CYCLES(MUTE)) u_dut_fast (
    .clk(clk), .rst(rst), .modekey_raw(raw2),
    .mode(mode2), .mode_strobe(strobe2), .mute(mute2)
  );

  // Cycle counter and reset-sample flag for the monitors.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push1();
    exp_t e;
    e.mode = nm1 + 2'b01;
    e.cyc  = cyc + LAT;
    q1.push_back(e);
    nm1 = nm1 + 2'b01;
  endtask

  task automatic push2();
    exp_t e;
    e.mode = nm2 + 2'b01;
    e.cyc  = cyc + LAT2;
    q2.push_back(e);
    nm2 = nm2 + 2'b01;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press1(input int hold, input int low);
    raw1 = 1'b1;
    push1();
    wait_n(hold);
    raw1 = 1'b0;
    wait_n(low);
  endtask

  task automatic reset_pulse(input int n);
    rst = 1'b1;
    nm1 = 2'b00;
    nm2 = 2'b00;
    wait_n(n);
    rst = 1'b0;
  endtask

  // Monitor for the main instance.
  initial begin : mon1
    exp_t       e;
    logic [1:0] exp_mode = 2'b00;
    int         mute_left = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst_seen) begin
          exp_mode  = 2'b00;
          mute_left = 0;
          chk("strobe1_in_reset", int'(strobe1), 0);
        end else if (strobe1) begin
          if (q1.size() == 0) begin
            chk("strobe1_unexpected", 1, 0);
          end else begin
            e = q1.pop_front();
            chk("strobe1_mode", int'(mode1), int'(e.mode));
            chk("strobe1_cycle", cyc, e.cyc);
            exp_mode = e.mode;
          end
          mute_left = MUTE;
        end
        chk("mode1", int'(mode1), int'(exp_mode));
        chk("mute1", int'(mute1), int'(mute_left != 0));
        if (mute_left > 0) mute_left--;
      end
    end
  end

  // Monitor for the fast-debounce instance.
  initial begin : mon2
    exp_t       e;
    logic [1:0] exp_mode = 2'b00;
    int         mute_left = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mute2) n_mute2_hi++;
        if (rst_seen) begin
          exp_mode  = 2'b00;
          mute_left = 0;
          chk("strobe2_in_reset", int'(strobe2), 0);
        end else if (strobe2) begin
          n_strobe2++;
          if (q2.size() == 0) begin
            chk("strobe2_unexpected", 1, 0);
          end else begin
            e = q2.pop_front();
            chk("strobe2_mode", int'(mode2), int'(e.mode));
            chk("strobe2_cycle", cyc, e.cyc);
            exp_mode = e.mode;
          end
          mute_left = MUTE;
        end
        chk("mode2", int'(mode2), int'(exp_mode));
        chk("mute2", int'(mute2), int'(mute_left != 0));
        if (mute_left > 0) mute_left--;
      end
    end
  end

  // Directed stimulus.
  initial begin : stim
    rst  = 1'b1;
    raw1 = 1'b0;
    raw2 = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    wait_n(2);
    rst = 1'b0;

    // Single press from reset: 01 with mute for 16 cycles.
    press1(30, 30);

    // Four clean presses from off: 01, 10, 11, 00.
    reset_pulse(3);
    wait_n(2);
    for (int i = 0; i < 4; i++) press1(20, 20);

    // Short press bounce: rejected.
    raw1 = 1'b1; wait_n(3);
    raw1 = 1'b0; wait_n(3);
    raw1 = 1'b1; wait_n(3);
    raw1 = 1'b0; wait_n(25);

    // Release bounce while held: one advance only (-> 01).
    raw1 = 1'b1;
    push1();
    wait_n(20);
    raw1 = 1'b0; wait_n(3);
    raw1 = 1'b1; wait_n(3);
    raw1 = 1'b0; wait_n(3);
    raw1 = 1'b1; wait_n(5);
    raw1 = 1'b0; wait_n(30);

    // Long hold: no auto-repeat (-> 10).
    press1(500, 30);

    // Reset during press debounce: mode returns to 00 and stays.
    raw1 = 1'b1;
    wait_n(5);
    raw1 = 1'b0;
    reset_pulse(1);
    wait_n(20);

    // Reset during mute window: mute drops right after.
    raw1 = 1'b1;
    push1();
    wait_n(14);
    raw1 = 1'b0;
    wait_n(3);
    reset_pulse(1);
    wait_n(20);

    // Key still held across reset: fresh press after reset releases.
    raw1 = 1'b1;
    push1();
    wait_n(20);
    reset_pulse(1);
    push1();
    wait_n(30);
    raw1 = 1'b0;
    wait_n(30);

    // Mute extension: two accepts 10 cycles apart on the fast instance.
    raw2 = 1'b1;
    push2();
    wait_n(7);
    raw2 = 1'b0;
    wait_n(3);
    raw2 = 1'b1;
    push2();
    wait_n(20);
    raw2 = 1'b0;
    wait_n(40);

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    chk("strobe2_count", n_strobe2, 2);
    chk("mute2_window_len", n_mute2_hi, 10 + MUTE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mode_ctrl.md
Name: mode_ctrl

Overview:
- Front-end controller for the synth's waveform-mode resource.
- Takes the raw, asynchronous mode push-button and synchronises and debounces it. Each clean press (press-and-release cycle) produces exactly one advance of the 2-bit mode: off → square → triangle → sawtooth → off.
- Drives a one-cycle change strobe and a timed mute window so the oscillator/DAC path can suppress the click at each waveform switch.
- Sits between the board button pad and the waveform generator / sample mux.

Parameters:
- DEB_CYCLES, 1000: cycles the synchronised key must stay stable before a press or release is accepted. Must be ≥ 2.
- MUTE_CYCLES, 256: length in cycles of the mute window after each mode change. Must be ≥ 1.
- DEB_W, $clog2(DEB_CYCLES): debounce counter width (derived, not overridden).
- MUTE_W, $clog2(MUTE_CYCLES+1): mute counter width (derived, not overridden).

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- modekey_raw  input  1  raw push-button level, asynchronous; 1 = pressed.
- mode  output  2  current mode: 00 off, 01 square, 10 triangle, 11 sawtooth.
- mode_strobe  output  1  one-cycle pulse, asserted in the cycle the new mode first appears on mode.
- mute  output  1  high while the post-change mute window is active.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-high and overrides all other activity, including mid-debounce and mid-mute.
  - Reset values: mode=00, mode_strobe=0, mute=0, FSM=IDLE, both counters=0, synchroniser flops=0.
- Synchroniser: two-flop chain modekey_raw → key_s. key_s lags the pad by 2 cycles. No logic may use modekey_raw directly.
- Debounce FSM, four states:
  - IDLE: if key_s=1, go to DEB_PRESS with cnt=0.
  - DEB_PRESS: if key_s=0, go to IDLE (glitch rejected, no advance). Otherwise cnt increments. When cnt==DEB_CYCLES-1 and key_s=1, go to HELD and issue accept.
  - HELD: if key_s=0, go to DEB_RELEASE with cnt=0. Holding the key never re-triggers (no auto-repeat).
  - DEB_RELEASE: if key_s=1, go back to HELD (bounce). Otherwise cnt increments. When cnt==DEB_CYCLES-1 and key_s=0, go to IDLE.
- Latency: if the pad goes high and stays stable from clock edge 0, mode updates at edge DEB_CYCLES+3.
- Accept handling:
  - mode <= mode+1 modulo 4; 11 wraps to 00.
  - mode_strobe=1 for exactly that one cycle.
  - Mute counter loads MUTE_CYCLES.
- Mute:
  - mute = (mute counter != 0).
  - The counter decrements each cycle while non-zero, so mute is high for exactly MUTE_CYCLES cycles, starting in the same cycle as mode_strobe.
  - An accept arriving while mute is active reloads the counter to MUTE_CYCLES; the window extends and does not stack.
- Transition into off (11 → 00) behaves identically: strobe fires and mute window runs.
- Any glitch shorter than DEB_CYCLES stable cycles, in either state, causes no mode change.
- Reset asserted in DEB_PRESS or HELD returns to IDLE. If the key is still held after reset releases, that counts as a fresh press and advances once after the full debounce.

Decomposition:
- Shared package tmnt_pkg:
  - mode_t enum: MODE_OFF=2'b00, MODE_SQUARE=2'b01, MODE_TRIANGLE=2'b10, MODE_SAW=2'b11.
  - key_state_t enum: IDLE, DEB_PRESS, HELD, DEB_RELEASE.
  - Defaults DEB_CYCLES_DEF and MUTE_CYCLES_DEF.
- One sub-module: key_debounce.
  - Contains the synchroniser, the four-state FSM and the debounce counter; outputs a single-cycle press_pulse.
  - mode_ctrl instantiates it and owns the mode register, the strobe and the mute counter.
  - key_debounce is reusable for other synth buttons.

Test Plan (DEB_CYCLES=8, MUTE_CYCLES=16):
- Reset and single press:
  - Assert rst 3 cycles → mode=00, mode_strobe=0, mute=0.
  - Raise raw at edge 0 and hold for 30 cycles → mode=01 at edge 11, mode_strobe high only in that cycle, mute high cycles 11–26.
- Full cycle and wrap: 4 clean press/release cycles, 40 cycles each → mode sequence 01, 10, 11, 00; exactly 4 strobes.
- Bounce rejection:
  - Raw toggles 1,0,1,0 every 3 cycles, then stays 0 → no mode change, no strobe.
  - Release bounce while in HELD → still exactly one advance.
- Long hold: raw held high for 500 cycles → exactly one advance, no auto-repeat.
- Mute extension: force two accepts 10 cycles apart (direct key_debounce press_pulse stimulus) → mute continuously high from the first strobe until 16 cycles after the second.
- Reset mid-operation:
  - rst pulsed during DEB_PRESS → mode stays 00.
  - rst pulsed during mute → mute=0 on the next cycle.
  - Key still held after rst releases → one advance, 11 cycles after rst deasserts.
